// File: rtl/sram_port_arbiter.sv
// Arbitrates a single-port synchronous SRAM between two functional requesters and a BIST engine.
// Functional reads return tagged data after RD_LAT edges; BIST takes the pins only once reads drain.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 10,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clock,
    input  logic              i_reset,

    input  logic              i_bist_en,
    input  logic              i_bist_csn,
    input  logic              i_bist_wen,
    input  logic [ADDR_W-1:0] i_bist_addr,
    input  logic [DATA_W-1:0] i_bist_wr_data,
    output logic              o_bist_active,

    input  logic              i_req0_valid,
    input  logic              i_req0_we,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_wr_data,
    output logic              o_req0_ready,
    output logic              o_req0_rvalid,
    output logic [DATA_W-1:0] o_req0_rd_data,

    input  logic              i_req1_valid,
    input  logic              i_req1_we,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wr_data,
    output logic              o_req1_ready,
    output logic              o_req1_rvalid,
    output logic [DATA_W-1:0] o_req1_rd_data,

    output logic              o_csn,
    output logic              o_wen,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wr_data,
    input  logic [DATA_W-1:0] i_rd_data
);

    typedef enum logic [1:0] {
        StFunc,
        StDrain,
        StBist
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    // Set when req1 held the most recent grant, so a tie goes to req0.
    logic              r_last;

    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_id;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_push;
    logic              w_tags_empty;
    logic              w_ret_vld;
    logic              w_ret_id;
    logic              w_bist_drive;

    // Round-robin grant; closed while BIST is requested so draining starts clean.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == StFunc && !i_bist_en && !i_reset) begin
            if (i_req0_valid && i_req1_valid) begin
                if (r_last) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end else if (i_req0_valid) begin
                w_grant0 = 1'b1;
            end else if (i_req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    assign w_push       = (w_grant0 && !i_req0_we) || (w_grant1 && !i_req1_we);
    assign w_tags_empty = ~|r_tag_vld;
    assign w_bist_drive = (r_state == StBist) && i_bist_en;

    always_comb begin
        o_csn     = 1'b1;
        o_wen     = 1'b1;
        o_addr    = '0;
        o_wr_data = '0;
        if (w_grant0) begin
            o_csn     = 1'b0;
            o_wen     = ~i_req0_we;
            o_addr    = i_req0_addr;
            o_wr_data = i_req0_wr_data;
        end else if (w_grant1) begin
            o_csn     = 1'b0;
            o_wen     = ~i_req1_we;
            o_addr    = i_req1_addr;
            o_wr_data = i_req1_wr_data;
        end else if (w_bist_drive) begin
            o_csn     = i_bist_csn;
            o_wen     = i_bist_wen;
            o_addr    = i_bist_addr;
            o_wr_data = i_bist_wr_data;
        end
    end

    assign o_bist_active = w_bist_drive;
    assign o_req0_ready  = w_grant0;
    assign o_req1_ready  = w_grant1;

    // The oldest tag lines up with the SRAM read data of the same cycle.
    assign w_ret_vld      = r_tag_vld[RD_LAT-1] && (r_state != StBist);
    assign w_ret_id       = r_tag_id[RD_LAT-1];
    assign o_req0_rvalid  = w_ret_vld && !w_ret_id;
    assign o_req1_rvalid  = w_ret_vld && w_ret_id;
    assign o_req0_rd_data = o_req0_rvalid ? i_rd_data : '0;
    assign o_req1_rd_data = o_req1_rvalid ? i_rd_data : '0;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFunc: begin
                if (i_bist_en) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (!i_bist_en) begin
                    w_state_next = StFunc;
                end else if (w_tags_empty) begin
                    w_state_next = StBist;
                end
            end
            StBist: begin
                if (!i_bist_en) begin
                    w_state_next = StFunc;
                end
            end
            default: w_state_next = StFunc;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StFunc;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_last <= 1'b1;
        end else if (w_grant0) begin
            r_last <= 1'b0;
        end else if (w_grant1) begin
            r_last <= 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_push;
            r_tag_id[0]  <= w_grant1;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: three instances (RD_LAT 1..3) share stimulus; a timestamp-based
// reference model checks every cycle, with directed table and sequence checks on top.
module tb_sram_port_arbiter;

    typedef struct packed {
        logic       csn;
        logic       wen;
        logic [7:0] addr;
        logic [9:0] wd;
        logic       rdy0;
        logic       rdy1;
        logic       rv0;
        logic       rv1;
        logic [9:0] rd0;
        logic [9:0] rd1;
        logic       act;
    } obs_t;

    typedef struct {
        logic       v0;
        logic       we0;
        logic [7:0] a0;
        logic [9:0] d0;
        logic       v1;
        logic       we1;
        logic [7:0] a1;
        logic [9:0] d1;
        obs_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       bist_en, bcsn, bwen;
    logic [7:0] baddr, a0, a1;
    logic [9:0] bwd, d0, d1;
    logic       v0, we0, v1, we1;

    logic       csn [3];
    logic       wen [3];
    logic [7:0] addr [3];
    logic [9:0] wd [3];
    logic       rdy0 [3];
    logic       rdy1 [3];
    logic       rv0 [3];
    logic       rv1 [3];
    logic       act [3];
    logic [9:0] rd0 [3];
    logic [9:0] rd1 [3];
    logic [9:0] srd [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_port_arbiter #(
            .ADDR_W(8),
            .DATA_W(10),
            .RD_LAT(g + 1)
        ) u_dut (
            .i_clock        (clk),
            .i_reset        (rst),
            .i_bist_en      (bist_en),
            .i_bist_csn     (bcsn),
            .i_bist_wen     (bwen),
            .i_bist_addr    (baddr),
            .i_bist_wr_data (bwd),
            .o_bist_active  (act[g]),
            .i_req0_valid   (v0),
            .i_req0_we      (we0),
            .i_req0_addr    (a0),
            .i_req0_wr_data (d0),
            .o_req0_ready   (rdy0[g]),
            .o_req0_rvalid  (rv0[g]),
            .o_req0_rd_data (rd0[g]),
            .i_req1_valid   (v1),
            .i_req1_we      (we1),
            .i_req1_addr    (a1),
            .i_req1_wr_data (d1),
            .o_req1_ready   (rdy1[g]),
            .o_req1_rvalid  (rv1[g]),
            .o_req1_rd_data (rd1[g]),
            .o_csn          (csn[g]),
            .o_wen          (wen[g]),
            .o_addr         (addr[g]),
            .o_wr_data      (wd[g]),
            .i_rd_data      (srd[g])
        );
    end

    // Behavioural SRAM per instance; junk on the data bus when no read is in flight.
    logic [9:0] smem [3][256];
    logic [9:0] rp [3][4];
    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (!csn[n] && !wen[n]) smem[n][addr[n]] <= wd[n];
            rp[n][0] <= (!csn[n] && wen[n]) ? smem[n][addr[n]] : 10'($urandom);
            for (int k = 1; k < 4; k++) rp[n][k] <= rp[n][k-1];
        end
    end
    always_comb begin
        for (int n = 0; n < 3; n++) srd[n] = rp[n][n];
    end

    // Reference model: mode 0=functional, 1=draining, 2=BIST; returns kept as due timestamps.
    int         mode [3];
    logic       last [3];
    int         cyc;
    logic       sv [3][8];
    int         sdue [3][8];
    logic       sid [3][8];
    logic [9:0] sdat [3][8];
    logic [9:0] mmem [3][256];

    int n_checks = 0;
    int n_fail = 0;

    function automatic obs_t expect_of(int n);
        obs_t e;
        logic g0, g1;
        e = '0;
        e.csn = 1'b1;
        e.wen = 1'b1;
        if (rst) return e;
        g0 = 1'b0;
        g1 = 1'b0;
        if (mode[n] == 0 && !bist_en) begin
            if (v0 && v1) begin
                g0 = last[n];
                g1 = !last[n];
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        if (g0) begin
            e.rdy0 = 1'b1; e.csn = 1'b0; e.wen = !we0; e.addr = a0; e.wd = d0;
        end else if (g1) begin
            e.rdy1 = 1'b1; e.csn = 1'b0; e.wen = !we1; e.addr = a1; e.wd = d1;
        end else if (mode[n] == 2 && bist_en) begin
            e.csn = bcsn; e.wen = bwen; e.addr = baddr; e.wd = bwd; e.act = 1'b1;
        end
        if (mode[n] != 2) begin
            for (int s = 0; s < 8; s++) begin
                if (sv[n][s] && sdue[n][s] == cyc) begin
                    if (sid[n][s]) begin
                        e.rv1 = 1'b1; e.rd1 = sdat[n][s];
                    end else begin
                        e.rv0 = 1'b1; e.rd0 = sdat[n][s];
                    end
                end
            end
        end
        return e;
    endfunction

    function automatic obs_t observe(int n);
        obs_t a;
        a.csn = csn[n]; a.wen = wen[n]; a.addr = addr[n]; a.wd = wd[n];
        a.rdy0 = rdy0[n]; a.rdy1 = rdy1[n]; a.rv0 = rv0[n]; a.rv1 = rv1[n];
        a.rd0 = rd0[n]; a.rd1 = rd1[n]; a.act = act[n];
        return a;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            mode[n] = 0;
            last[n] = 1'b1;
            for (int s = 0; s < 8; s++) sv[n][s] = 1'b0;
        end
    endtask

    task automatic model_step();
        obs_t e;
        logic empty;
        for (int n = 0; n < 3; n++) begin
            e = expect_of(n);
            empty = 1'b1;
            for (int s = 0; s < 8; s++) if (sv[n][s] && sdue[n][s] >= cyc) empty = 1'b0;
            for (int s = 0; s < 8; s++) if (sv[n][s] && sdue[n][s] <= cyc) sv[n][s] = 1'b0;
            if (!e.csn && !e.wen) mmem[n][e.addr] = e.wd;
            if ((e.rdy0 && !we0) || (e.rdy1 && !we1)) begin
                for (int s = 0; s < 8; s++) begin
                    if (!sv[n][s]) begin
                        sv[n][s]   = 1'b1;
                        sdue[n][s] = cyc + n + 1;
                        sid[n][s]  = e.rdy1;
                        sdat[n][s] = mmem[n][e.addr];
                        break;
                    end
                end
            end
            if (e.rdy0) last[n] = 1'b0;
            else if (e.rdy1) last[n] = 1'b1;
            case (mode[n])
                0: if (bist_en) mode[n] = 1;
                1: if (!bist_en) mode[n] = 0; else if (empty) mode[n] = 2;
                default: if (!bist_en) mode[n] = 0;
            endcase
        end
        cyc++;
    endtask

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic chk_obs(string nm, obs_t a, obs_t e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < 256; i++) begin
                smem[n][i] = '0;
                mmem[n][i] = '0;
            end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                chk_obs($sformatf("model inst%0d cyc%0d", n, cyc), observe(n), expect_of(n));
            end
        end
    end

    function automatic obs_t mko(logic c, logic w, logic [7:0] ad, logic [9:0] dt, logic r0,
                                 logic r1, logic q0, logic q1, logic [9:0] x0, logic [9:0] x1);
        obs_t o;
        o.csn = c; o.wen = w; o.addr = ad; o.wd = dt; o.rdy0 = r0; o.rdy1 = r1;
        o.rv0 = q0; o.rv1 = q1; o.rd0 = x0; o.rd1 = x1; o.act = 1'b0;
        return o;
    endfunction

    function automatic vec_t mkv(logic p0, logic w0, logic [7:0] b0, logic [9:0] c0, logic p1,
                                 logic w1, logic [7:0] b1, logic [9:0] c1, obs_t e);
        vec_t r;
        r.v0 = p0; r.we0 = w0; r.a0 = b0; r.d0 = c0;
        r.v1 = p1; r.we1 = w1; r.a1 = b1; r.d1 = c1; r.e = e;
        return r;
    endfunction

    task automatic set_idle();
        v0 = 0; we0 = 0; a0 = '0; d0 = '0;
        v1 = 0; we1 = 0; a1 = '0; d1 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = mkv(1, 1, 8'h12, 10'h2AA, 0, 0, 8'h00, 10'h000,
                      mko(0, 0, 8'h12, 10'h2AA, 1, 0, 0, 0, 10'h000, 10'h000));
        tbl[1]  = mkv(1, 0, 8'h12, 10'h000, 0, 0, 8'h00, 10'h000,
                      mko(0, 1, 8'h12, 10'h000, 1, 0, 0, 0, 10'h000, 10'h000));
        tbl[2]  = mkv(0, 0, 8'h00, 10'h000, 0, 0, 8'h00, 10'h000,
                      mko(1, 1, 8'h00, 10'h000, 0, 0, 1, 0, 10'h2AA, 10'h000));
        tbl[3]  = mkv(1, 1, 8'h01, 10'h0AB, 0, 0, 8'h00, 10'h000,
                      mko(0, 0, 8'h01, 10'h0AB, 1, 0, 0, 0, 10'h000, 10'h000));
        tbl[4]  = mkv(0, 0, 8'h00, 10'h000, 1, 1, 8'h02, 10'h155,
                      mko(0, 0, 8'h02, 10'h155, 0, 1, 0, 0, 10'h000, 10'h000));
        tbl[5]  = mkv(1, 0, 8'h01, 10'h000, 1, 0, 8'h02, 10'h000,
                      mko(0, 1, 8'h01, 10'h000, 1, 0, 0, 0, 10'h000, 10'h000));
        tbl[6]  = mkv(1, 0, 8'h01, 10'h000, 1, 0, 8'h02, 10'h000,
                      mko(0, 1, 8'h02, 10'h000, 0, 1, 1, 0, 10'h0AB, 10'h000));
        tbl[7]  = mkv(1, 0, 8'h01, 10'h000, 1, 0, 8'h02, 10'h000,
                      mko(0, 1, 8'h01, 10'h000, 1, 0, 0, 1, 10'h000, 10'h155));
        tbl[8]  = mkv(1, 0, 8'h01, 10'h000, 1, 0, 8'h02, 10'h000,
                      mko(0, 1, 8'h02, 10'h000, 0, 1, 1, 0, 10'h0AB, 10'h000));
        tbl[9]  = mkv(1, 0, 8'h01, 10'h000, 1, 0, 8'h02, 10'h000,
                      mko(0, 1, 8'h01, 10'h000, 1, 0, 0, 1, 10'h000, 10'h155));
        tbl[10] = mkv(1, 0, 8'h01, 10'h000, 1, 0, 8'h02, 10'h000,
                      mko(0, 1, 8'h02, 10'h000, 0, 1, 1, 0, 10'h0AB, 10'h000));
        tbl[11] = mkv(0, 0, 8'h00, 10'h000, 0, 0, 8'h00, 10'h000,
                      mko(1, 1, 8'h00, 10'h000, 0, 0, 0, 1, 10'h000, 10'h155));
        tbl[12] = mkv(0, 0, 8'h00, 10'h000, 0, 0, 8'h00, 10'h000,
                      mko(1, 1, 8'h00, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000));

        // Reset held with both requesters valid: nothing may be granted.
        set_idle();
        v0 = 1; v1 = 1;
        bist_en = 0; bcsn = 1; bwen = 1; baddr = '0; bwd = '0;
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            chk_obs($sformatf("in reset inst%0d", n), observe(n),
                    mko(1, 1, 8'h00, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000));
        end
        next_cycle();
        rst = 0;
        set_idle();
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            chk_obs($sformatf("reset release inst%0d", n), observe(n),
                    mko(1, 1, 8'h00, 10'h000, 0, 0, 0, 0, 10'h000, 10'h000));
        end

        for (int i = 0; i < 13; i++) begin
            next_cycle();
            v0 = tbl[i].v0; we0 = tbl[i].we0; a0 = tbl[i].a0; d0 = tbl[i].d0;
            v1 = tbl[i].v1; we1 = tbl[i].we1; a1 = tbl[i].a1; d1 = tbl[i].d1;
            @(negedge clk);
            chk_obs($sformatf("table row %0d", i), observe(0), tbl[i].e);
        end

        // RD_LAT=3: req1 read accepted on the edge where BIST is requested.
        next_cycle();
        set_idle();
        v1 = 1; a1 = 8'h02;
        @(negedge clk);
        chk("bist accept rdy1", rdy1[2], 1);
        next_cycle();
        set_idle();
        v0 = 1; a0 = 8'h12;
        bist_en = 1; bcsn = 0; bwen = 0; baddr = 8'h33; bwd = 10'h3C3;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("drain c%0d rdy0", c), rdy0[2], 0);
            chk($sformatf("drain c%0d rv1", c), rv1[2], (c == 3) ? 1 : 0);
            chk($sformatf("drain c%0d act", c), act[2], (c == 5) ? 1 : 0);
            if (c == 3) chk("drain rd1", rd1[2], 10'h155);
            if (c < 5) chk($sformatf("drain c%0d csn", c), csn[2], 1);
            if (c < 5) next_cycle();
        end
        chk("bist csn", csn[2], 0);
        chk("bist wen", wen[2], 0);
        chk("bist addr", addr[2], 8'h33);
        chk("bist wdata", wd[2], 10'h3C3);

        // BIST release with req0 waiting: one idle cycle, then the grant.
        next_cycle();
        bist_en = 0;
        @(negedge clk);
        chk("exit csn", csn[2], 1);
        chk("exit wen", wen[2], 1);
        chk("exit addr", addr[2], 0);
        chk("exit rdy0", rdy0[2], 0);
        next_cycle();
        @(negedge clk);
        chk("resume rdy0", rdy0[2], 1);
        chk("resume csn", csn[2], 0);
        chk("resume addr", addr[2], 8'h12);
        next_cycle();
        set_idle();
        repeat (4) next_cycle();

        // RD_LAT=2: reset one cycle after a read is accepted drops the return.
        v0 = 1; a0 = 8'h12;
        @(negedge clk);
        chk("rst seq accept", rdy0[1], 1);
        next_cycle();
        set_idle();
        rst = 1;
        @(negedge clk);
        chk("rst seq csn", csn[1], 1);
        chk("rst seq rv0", rv0[1], 0);
        chk("rst seq act", act[1], 0);
        next_cycle();
        rst = 0;
        v0 = 1; we0 = 1; a0 = 8'h40; d0 = 10'h011;
        v1 = 1; we1 = 1; a1 = 8'h41; d1 = 10'h022;
        @(negedge clk);
        chk("post rst rv0", rv0[1], 0);
        chk("post rst rdy0", rdy0[1], 1);
        chk("post rst rdy1", rdy1[1], 0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            set_idle();
            @(negedge clk);
            chk($sformatf("post rst quiet%0d", c), {31'd0, rv0[1] | rv1[1]}, 0);
        end

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 11) == 0) bist_en = ~bist_en;
            bcsn = 1'($urandom); bwen = 1'($urandom);
            baddr = 8'($urandom_range(0, 15)); bwd = 10'($urandom);
            v0 = ($urandom_range(0, 9) < 6); we0 = 1'($urandom);
            a0 = 8'($urandom_range(0, 15)); d0 = 10'($urandom);
            v1 = ($urandom_range(0, 9) < 6); we1 = 1'($urandom);
            a1 = 8'($urandom_range(0, 15)); d1 = 10'($urandom);
        end
        next_cycle();
        rst = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
